// File: rtl/bidir_line_responder_if.sv
// rtl/bidir_line_responder_if.sv - host-side status and response handshake bundle for the line responder
interface bidir_line_responder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       resp_ready;
    logic       resp_valid;
    logic [7:0] resp_data;
    logic       timeout;
    logic       drive_en;
    logic       busy;

    modport master (
        input  rx_data, rx_valid, frame_err, resp_ready, timeout, drive_en, busy,
        output resp_valid, resp_data
    );

    modport slave (
        output rx_data, rx_valid, frame_err, resp_ready, timeout, drive_en, busy,
        input  resp_valid, resp_data
    );
endinterface

// File: rtl/bidir_line_responder.sv
// rtl/bidir_line_responder.sv - half-duplex single-wire responder: receive request byte, turn around, send reply
module bidir_line_responder #(
    parameter int BIT_CYCLES  = 16,
    parameter int TURN_CYCLES = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    inout  wire                     bidir_signal,
    bidir_line_responder_if.slave   bus
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] TURN     = 3'd4;
    localparam logic [2:0] TX_START = 3'd5;
    localparam logic [2:0] TX_DATA  = 3'd6;
    localparam logic [2:0] TX_STOP  = 3'd7;

    localparam int MAXC = (TURN_CYCLES > BIT_CYCLES) ? TURN_CYCLES : BIT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_shift;
    logic [7:0]    rx_data;
    logic [7:0]    tx_shift;
    logic          tx_bit;
    logic          drive_en;
    logic          have_resp;
    logic          rx_valid;
    logic          frame_err;
    logic          timeout;
    logic          line_meta;
    logic          line_sync;
    logic          line_rx;
    logic          bit_end;
    logic          half_end;
    logic          turn_end;
    logic          resp_ready;
    logic          accept;

    assign bidir_signal = drive_en ? tx_bit : 1'bz;

    always_ff @(posedge clk) begin
        if (rst) begin
            line_meta <= 1'b1;
            line_sync <= 1'b1;
        end else begin
            line_meta <= bidir_signal;
            line_sync <= line_meta;
        end
    end

    // Our own transmission echoes back through the synchronizer; never treat it as receive data.
    assign line_rx    = drive_en ? 1'b1 : line_sync;
    assign bit_end    = (cnt == CW'(BIT_CYCLES - 1));
    assign half_end   = (cnt == CW'(BIT_CYCLES / 2 - 1));
    assign turn_end   = (cnt == CW'(TURN_CYCLES - 1));
    assign resp_ready = (state == TURN) && !have_resp;
    assign accept     = resp_ready && bus.resp_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            rx_shift  <= 8'h00;
            rx_data   <= 8'h00;
            tx_shift  <= 8'h00;
            tx_bit    <= 1'b1;
            drive_en  <= 1'b0;
            have_resp <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= 3'd0;
                    if (!line_rx) state <= RX_START;
                end
                RX_START: begin
                    if (half_end) begin
                        cnt   <= '0;
                        state <= line_rx ? IDLE : RX_DATA;
                    end else cnt <= cnt + 1'b1;
                end
                RX_DATA: begin
                    if (bit_end) begin
                        cnt      <= '0;
                        rx_shift <= {line_rx, rx_shift[7:1]};
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else cnt <= cnt + 1'b1;
                end
                RX_STOP: begin
                    if (bit_end) begin
                        cnt       <= '0;
                        have_resp <= 1'b0;
                        if (line_rx) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                            state    <= TURN;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end else cnt <= cnt + 1'b1;
                end
                TURN: begin
                    if (accept) begin
                        tx_shift  <= bus.resp_data;
                        have_resp <= 1'b1;
                    end
                    // The window length is fixed; an early accept does not shorten it.
                    if (turn_end) begin
                        cnt <= '0;
                        if (have_resp || accept) begin
                            state    <= TX_START;
                            drive_en <= 1'b1;
                            tx_bit   <= 1'b0;
                        end else begin
                            timeout <= 1'b1;
                            state   <= IDLE;
                        end
                    end else cnt <= cnt + 1'b1;
                end
                TX_START: begin
                    if (bit_end) begin
                        cnt      <= '0;
                        bit_idx  <= 3'd0;
                        tx_bit   <= tx_shift[0];
                        tx_shift <= {1'b0, tx_shift[7:1]};
                        state    <= TX_DATA;
                    end else cnt <= cnt + 1'b1;
                end
                TX_DATA: begin
                    if (bit_end) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            tx_bit <= 1'b1;
                            state  <= TX_STOP;
                        end else begin
                            tx_bit   <= tx_shift[0];
                            tx_shift <= {1'b0, tx_shift[7:1]};
                        end
                    end else cnt <= cnt + 1'b1;
                end
                TX_STOP: begin
                    if (bit_end) begin
                        cnt      <= '0;
                        drive_en <= 1'b0;
                        state    <= IDLE;
                    end else cnt <= cnt + 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    drive_en <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rx_data    = rx_data;
    assign bus.rx_valid   = rx_valid;
    assign bus.frame_err  = frame_err;
    assign bus.resp_ready = resp_ready;
    assign bus.timeout    = timeout;
    assign bus.drive_en   = drive_en;
    assign bus.busy       = (state != IDLE);
endmodule
